// File: rtl/shift_exec_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_exec_stage_pkg                                            |
// | Purpose  : Shared widths, limits and flag bit positions for the shift unit |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package shift_exec_stage_pkg;

    localparam int c_WIDTH   = 16;
    localparam int c_AMT_W   = 5;
    localparam int c_TAG_W   = 4;
    localparam int c_AMT_MIN = -16;

    // Bit positions inside the registered flag vector
    localparam int c_FLAG_C = 0;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_N = 2;
    localparam int c_FLAG_W = 3;

endpackage
`default_nettype wire

// File: rtl/shift_exec_stage_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_core                                                      |
// | Purpose  : Combinational left/right barrel shift with last-bit-out carry   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_core
    import shift_exec_stage_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int MAG_W = c_AMT_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic             dir,
    input  logic [MAG_W-1:0] mag,
    input  logic             arith,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic             w_fill;
    logic [WIDTH:0]   w_left;
    logic [2*WIDTH:0] w_right;

    // A guard bit beside the operand catches the last bit shifted out in either direction
    always_comb begin
        w_fill  = arith & x[WIDTH-1];
        w_left  = {1'b0, x} << mag;
        w_right = {{WIDTH{w_fill}}, x, 1'b0} >> mag;
        if (dir) begin
            res   = w_right[WIDTH:1];
            carry = w_right[0];
        end else begin
            res   = w_left[WIDTH-1:0];
            carry = w_left[WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_exec_stage                                                |
// | Purpose  : Two-stage pipelined shift unit with valid/ready on both sides   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int AMT_W = c_AMT_W,
    parameter int TAG_W = c_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             in_arith,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg
);

    logic                r_s1_valid;
    logic [WIDTH-1:0]    r_s1_data;
    logic                r_s1_arith;
    logic [TAG_W-1:0]    r_s1_tag;
    logic                r_s1_dir;
    logic [AMT_W-1:0]    r_s1_mag;

    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_s2_data;
    logic [TAG_W-1:0]    r_s2_tag;
    logic [c_FLAG_W-1:0] r_s2_flags;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic [AMT_W-1:0]    w_mag;
    logic [WIDTH-1:0]    w_res;
    logic                w_carry;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv && !flush;

    // Magnitude of -16 wraps to 5'b10000, which reads correctly as unsigned 16
    assign w_mag = in_amount[AMT_W-1] ? -in_amount : in_amount;

    shift_core #(
        .WIDTH (WIDTH),
        .MAG_W (AMT_W)
    ) u_core (
        .x     (r_s1_data),
        .dir   (r_s1_dir),
        .mag   (r_s1_mag),
        .arith (r_s1_arith),
        .res   (w_res),
        .carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_arith <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_dir   <= 1'b0;
            r_s1_mag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
            r_s2_flags <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data            <= w_res;
                    r_s2_tag             <= r_s1_tag;
                    r_s2_flags[c_FLAG_C] <= w_carry;
                    r_s2_flags[c_FLAG_Z] <= (w_res == '0);
                    r_s2_flags[c_FLAG_N] <= w_res[WIDTH-1];
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data  <= in_data;
                    r_s1_arith <= in_arith;
                    r_s1_tag   <= in_tag;
                    r_s1_dir   <= in_amount[AMT_W-1];
                    r_s1_mag   <= w_mag;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;
    assign out_carry = r_s2_flags[c_FLAG_C];
    assign out_zero  = r_s2_flags[c_FLAG_Z];
    assign out_neg   = r_s2_flags[c_FLAG_N];

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shift_exec_stage                                             |
// | Purpose  : Scoreboard bench for shift_exec_stage with a behavioural model  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [4:0]  in_amount = '0;
    logic        in_arith = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_carry;
    logic        out_zero;
    logic        out_neg;

    shift_exec_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_arith  (in_arith),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  t;
        logic        c;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   or_mode  = 0;
    int   base     = 0;
    bit   mon_en   = 0;
    bit   saw_block = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Shift semantics from the arithmetic definition: multiply/divide by powers of two
    function automatic void model(input logic [15:0] x, input int amt, input bit ar,
                                  output logic [15:0] r, output bit c);
        int s;
        int k;
        if (amt == 0) begin
            r = x;
            c = 1'b0;
        end else if (amt > 0) begin
            r = 16'(int'(x) * (1 << amt));
            c = x[16-amt];
        end else begin
            k = -amt;
            s = ar ? int'($signed(x)) : int'(x);
            r = 16'(s >>> k);
            c = x[k-1];
        end
    endfunction

    // out_ready policy: 0 always ready, 1 random, 2 low for cycles 3..5 after base, 3 never
    initial begin
        forever begin
            @(negedge clk);
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 9) < 7);
                2: out_ready = !((cyc - base) >= 3 && (cyc - base) <= 5);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [15:0] x, input int amt, input bit ar, input logic [3:0] tag,
                        input logic [15:0] ed, input bit ec, input bit lat);
        int   waited = 0;
        bit   done = 0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = x;
            in_amount = 5'(amt);
            in_arith  = ar;
            in_tag    = tag;
            #1;
            if (in_ready) begin
                e.d = ed; e.t = tag; e.c = ec; e.acc = cyc; e.lat = lat;
                sb.push_back(e);
                done = 1;
            end else begin
                saw_block = 1;
                waited++;
                if (waited > 200) begin
                    chk("accept_timeout", 32'(in_ready), 32'd1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [15:0] x, input int amt, input bit ar, input logic [3:0] tag);
        logic [15:0] r;
        bit          c;
        model(x, amt, ar, r, c);
        send(x, amt, ar, tag, r, c, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops on each output handshake and checks stability while stalled
    initial begin
        exp_t        e;
        bit          have_prev = 0;
        logic [23:0] snap = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (have_prev && out_valid)
                    chk("stall_stable", {out_data, out_tag, out_carry, out_zero, out_neg, 1'b0}, snap);
                have_prev = out_valid && !out_ready;
                snap = {out_data, out_tag, out_carry, out_zero, out_neg, 1'b0};
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output_tag", 32'(out_tag), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_tag", 32'(out_tag), 32'(e.t));
                        chk("out_flags_czn", {29'd0, out_carry, out_zero, out_neg},
                            {29'd0, e.c, (e.d == 16'h0), e.d[15]});
                        if (e.lat)
                            chk("latency", 32'(cyc - e.acc), 32'd2);
                    end
                end
            end
        end
    end

    initial begin
        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", {29'd0, out_carry, out_zero, out_neg}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1;

        // Directed boundary cases, ready held high so latency is checked
        or_mode = 0;
        send(16'h8001,   1, 1'b0, 4'd1, 16'h0002, 1'b1, 1'b1);
        send(16'h8000, -15, 1'b1, 4'd2, 16'hFFFF, 1'b0, 1'b1);
        send(16'h8000, -15, 1'b0, 4'd3, 16'h0001, 1'b0, 1'b1);
        send(16'h8000, -16, 1'b0, 4'd4, 16'h0000, 1'b1, 1'b1);
        send(16'h8000, -16, 1'b1, 4'd5, 16'hFFFF, 1'b1, 1'b1);
        send(16'h1234,   0, 1'b1, 4'd6, 16'h1234, 1'b0, 1'b1);
        send(16'h0001,  15, 1'b0, 4'd7, 16'h8000, 1'b0, 1'b1);
        send(16'h4000,  15, 1'b0, 4'd8, 16'h0000, 1'b0, 1'b1);
        drain();

        // Six back-to-back ops with out_ready low for cycles 3..5
        saw_block = 0;
        base = cyc;
        or_mode = 2;
        for (int i = 0; i < 6; i++)
            send_rand(16'(16'h1111 * (i + 1)), i - 2, 1'b1, 4'(i));
        drain();
        chk("in_ready_dropped", 32'(saw_block), 32'd1);

        // Random traffic with random backpressure
        or_mode = 1;
        for (int i = 0; i < 120; i++) begin
            send_rand(16'($urandom), int'($urandom_range(0, 31)) - 16, 1'($urandom), 4'(i));
            if ($urandom_range(0, 4) == 0) @(posedge clk);
        end
        drain();

        // Flush with both stages full and a new op offered in the flush cycle
        or_mode = 3;
        send_rand(16'hA5A5, 3, 1'b0, 4'hA);
        send_rand(16'h5A5A, -3, 1'b1, 4'hB);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0F0F; in_amount = 5'd1; in_tag = 4'hC;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk); #2;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        or_mode = 0;
        send(16'h00F0, 4, 1'b0, 4'hD, 16'h0F00, 1'b0, 1'b1);
        drain();

        // Reset with an op in flight clears outputs too
        or_mode = 3;
        send_rand(16'h7777, -1, 1'b0, 4'hE);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clk); #2;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_tag", 32'(out_tag), 32'd0);
        or_mode = 0;
        repeat (4) @(posedge clk);
        chk("midrst_no_ghost", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
